// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//
// Multicycle fetch stage. Owns the program counter (PC) and the instruction
// register (IR) and drives the instruction memory byte address. A fetch
// request in IDLE presents the fetch address to memory. The unit then waits
// MEM_WAIT cycles for the combinational read to settle. It then latches the
// word into IR and advances PC by 4. Between fetches, PC can be loaded from
// PC+4, a branch target or a jump target.
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN
//   defined   : misaligned or out-of-range fetch addresses (above ADDR_LIMIT)
//               are rejected. IR is cleared, FetchDone pulses, and the sticky
//               AddrFault flag is set.
//   undefined : no check is made. The low two address bits are forced to 00
//               and AddrFault is tied low.
//
// Parameters
//   RESET_PC     PC / Address value after reset
//   MEM_WAIT     settle cycles between Address update and IR capture (0..15)
//   ADDR_LIMIT   highest legal word byte-address (only with the check built)
//
// Ports
//   Clk           in   rising-edge clock
//   Rst_n         in   asynchronous active-low reset
//   FetchReq      in   start a fetch at current PC (sampled only in IDLE)
//   PCWrite       in   load PC from PCSrc selection (sampled only in IDLE)
//   PCSrc[1:0]    in   00 PC+4, 01 BranchTarget, 10 JumpTarget, 11 hold
//   BranchTarget  in   branch target byte address
//   JumpTarget    in   jump target byte address
//   Instruction   in   read data from instruction memory
//   Address       out  registered byte address to instruction memory
//   IR            out  latched instruction
//   PC            out  current program counter
//   PCPlus4       out  PC + 4 (combinational, wraps modulo 2^32)
//   FetchDone     out  one-cycle pulse after IR has been updated
//   Busy          out  high while waiting for memory
//   AddrFault     out  sticky illegal-address flag
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MEM_WAIT = 1
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  parameter logic [31:0] ADDR_LIMIT = 32'd1020
`endif
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        FetchReq,
  input  logic        PCWrite,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] BranchTarget,
  input  logic [31:0] JumpTarget,
  input  logic [31:0] Instruction,
  output logic [31:0] Address,
  output logic [31:0] IR,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        FetchDone,
  output logic        Busy,
  output logic        AddrFault
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam logic [3:0] WaitCycles = 4'(MEM_WAIT);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] ir_q, ir_d;
  logic        fetchDone_q, fetchDone_d;

  logic [31:0] srcSel;
  logic [31:0] fetchAddr;

  assign PCPlus4 = pc_q + 32'd4;

  // Candidate PC value selected by PCSrc; 11 keeps PC where it is.
  always_comb begin
    srcSel = pc_q;
    case (PCSrc)
      2'b00:   srcSel = PCPlus4;
      2'b01:   srcSel = BranchTarget;
      2'b10:   srcSel = JumpTarget;
      default: srcSel = pc_q;
    endcase
  end

  // A fetch that coincides with PCWrite goes straight to the new target.
  assign fetchAddr = PCWrite ? srcSel : pc_q;

`ifdef FETCH_ALIGN_CHECK_EN
  logic addrFault_q, addrFault_d;
  logic fetchBad;

  assign fetchBad = (fetchAddr[1:0] != 2'b00) || (fetchAddr > ADDR_LIMIT);
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_d        = pc_q;
    addr_d      = addr_q;
    ir_d        = ir_q;
    fetchDone_d = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    addrFault_d = addrFault_q;
`endif
    case (state_q)
      IDLE: begin
        if (FetchReq) begin
`ifdef FETCH_ALIGN_CHECK_EN
          // Rejected fetches complete immediately with a zero instruction
          // so the control FSM sees a normal FetchDone handshake.
          if (fetchBad) begin
            ir_d        = 32'h0000_0000;
            fetchDone_d = 1'b1;
            addrFault_d = 1'b1;
          end else begin
            pc_d    = fetchAddr;
            addr_d  = fetchAddr;
            cnt_d   = WaitCycles;
            state_d = WAIT;
          end
`else
          pc_d    = fetchAddr;
          addr_d  = {fetchAddr[31:2], 2'b00};
          cnt_d   = WaitCycles;
          state_d = WAIT;
`endif
        end else if (PCWrite) begin
          pc_d = srcSel;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          ir_d        = Instruction;
          pc_d        = PCPlus4;
          fetchDone_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      pc_q        <= RESET_PC;
      addr_q      <= RESET_PC;
      ir_q        <= 32'h0000_0000;
      fetchDone_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      ir_q        <= ir_d;
      fetchDone_q <= fetchDone_d;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      addrFault_q <= 1'b0;
    end else begin
      addrFault_q <= addrFault_d;
    end
  end

  assign AddrFault = addrFault_q;
`else
  assign AddrFault = 1'b0;
`endif

  assign Address   = addr_q;
  assign IR        = ir_q;
  assign PC        = pc_q;
  assign FetchDone = fetchDone_q;
  assign Busy      = (state_q == WAIT);

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Multicycle fetch stage that owns the program counter and instruction register and drives the instruction memory address. On a fetch request from the main control FSM it presents the PC to the instruction memory, waits a configurable number of cycles for the combinational read to settle, latches the word into IR and advances PC by 4. Branch and jump targets computed elsewhere are loaded into PC through a small select port between fetches.

## Interface
- RESET_PC, 32'h0000_0000, PC and Address value after reset
- MEM_WAIT, 1, settle cycles between Address update and Instruction sample; legal 0..15
- ADDR_LIMIT, 1020, highest legal word byte-address (256-word store)
- Clk  in  1  rising-edge clock
- Rst_n  in  1  asynchronous, active-low reset
- FetchReq  in  1  start a fetch at current PC (sampled only in IDLE)
- PCWrite  in  1  load PC from PCSrc selection (sampled only in IDLE)
- PCSrc  in  2  00 PC+4, 01 BranchTarget, 10 JumpTarget, 11 hold
- BranchTarget  in  32  branch target byte address
- JumpTarget  in  32  jump target byte address
- Instruction  in  32  read data from instruction memory
- Address  out  32  registered byte address to instruction memory
- IR  out  32  latched instruction
- PC  out  32  current program counter
- PCPlus4  out  32  PC + 4, combinational, modulo 2^32
- FetchDone  out  1  one-cycle pulse: IR just updated
- Busy  out  1  high whenever state is WAIT
- AddrFault  out  1  sticky illegal-address flag (see Configuration)

## Operation
- States: IDLE, WAIT. Counter cnt, 4 bits.
- IDLE, FetchReq=0, PCWrite=1: PC <= selected source; stay IDLE.
- IDLE, FetchReq=1: fetch address F = (PCWrite ? selected source : PC); PC <= F; Address <= F; cnt <= MEM_WAIT; go WAIT.
- WAIT, cnt≠0: cnt <= cnt-1.
- WAIT, cnt=0: IR <= Instruction; PC <= PC+4; FetchDone <= 1; go IDLE.
- FetchReq/PCWrite while Busy: ignored, no queuing.
- PCSrc=11 with PCWrite=1: PC unchanged (still counts as accepted).
- PC+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000 with no flag.
- IR and Address hold between fetches; IR never changes except at capture.

## Timing
- Reset (async assert, sync-free): PC=RESET_PC, Address=RESET_PC, IR=0, FetchDone=0, Busy=0, AddrFault=0, cnt=0, state IDLE. Reset during WAIT aborts the fetch; no FetchDone.
- FetchReq sampled at edge E: Address valid after E; IR/PC updated at edge E+MEM_WAIT+1; FetchDone high for exactly the cycle after that edge.
- Fetch-to-fetch throughput: MEM_WAIT+2 cycles; FetchReq held high during the FetchDone cycle is accepted at the next edge (back-to-back).
- Busy rises after E, falls at the capture edge.
- PCPlus4 follows PC with zero latency.

## Configuration
- FETCH_ALIGN_CHECK_EN defined: in IDLE, a FetchReq whose F has F[1:0]≠00 or F>ADDR_LIMIT is rejected: no WAIT, Address and PC unchanged, IR <= 32'h0000_0000, FetchDone pulses next cycle, AddrFault <= 1 (sticky until reset).
- Undefined: no check; Address low two bits forced to 00; AddrFault tied 0; out-of-range addresses fetched as normal.

## Test plan
- Reset with RESET_PC=0, memory word0=32'h2013_0001: FetchReq pulse -> IR=32'h2013_0001, PC=4 at edge MEM_WAIT+1, FetchDone one cycle, Busy high MEM_WAIT+1 cycles.
- FetchReq held high, MEM_WAIT=1, 5 fetches -> Address 0,4,8,12,16, FetchDone every 3rd cycle, IR tracks words 0..4.
- IDLE, PC=56, PCWrite=1, PCSrc=01, BranchTarget=20, FetchReq=1 same edge -> Address=20, IR=word5, PC=24.
- PCWrite=1, PCSrc=10, JumpTarget=64 asserted while Busy -> ignored; after fetch PC = old PC+4.
- Rst_n low mid-WAIT -> all outputs reset values immediately, no FetchDone; PC=32'hFFFF_FFFC fetch (check undefined) -> PC=0 after capture.
- FETCH_ALIGN_CHECK_EN, PC=1024 or PC=6 FetchReq -> IR=0, AddrFault=1, PC unchanged, FetchDone pulses, Busy stays 0.
